// File: rtl/tick_monitor.sv
// Watches a periodic tick stream, measures each interval and classifies it
// against an N+1 +/- TOL window; locks after LOCK good intervals in a row.
module tick_monitor #(
  parameter int N     = 200000,
  parameter int CBITS = 18,
  parameter int TOL   = 2,
  parameter int LOCK  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             tick,
  input  logic             clr,
  output logic             locked,
  output logic             fault,
  output logic             early,
  output logic             late,
  output logic [CBITS-1:0] period,
  output logic [7:0]       good_cnt
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ACQ    = 3'd1,
    TRACK  = 3'd2,
    LOCKED = 3'd3,
    FAULT  = 3'd4
  } state_t;

  localparam logic [CBITS-1:0] TIMEOUT = CBITS'(N + TOL + 1);
  localparam logic [CBITS-1:0] WIN_LO  = CBITS'(N + 1 - TOL);
  localparam logic [7:0]       LOCK_C  = 8'(LOCK);

  state_t           state;
  logic [CBITS-1:0] gcnt;
  logic [CBITS-1:0] interval;
  logic [7:0]       good_inc;

  // gcnt never exceeds TIMEOUT while tracking, so gcnt+1 cannot overflow.
  assign interval = gcnt + CBITS'(1);
  assign good_inc = (good_cnt == 8'hFF) ? good_cnt : good_cnt + 8'd1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      gcnt     <= '0;
      locked   <= 1'b0;
      fault    <= 1'b0;
      early    <= 1'b0;
      late     <= 1'b0;
      period   <= '0;
      good_cnt <= '0;
    end else begin
      early <= 1'b0;
      late  <= 1'b0;
      if (!en) begin
        state    <= IDLE;
        gcnt     <= '0;
        good_cnt <= '0;
        locked   <= 1'b0;
        fault    <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            state <= ACQ;
            gcnt  <= '0;
          end
          ACQ: begin
            // First tick only sets the phase reference; no interval yet.
            if (tick) begin
              state    <= TRACK;
              gcnt     <= '0;
              good_cnt <= '0;
            end else if (gcnt != '1) begin
              gcnt <= gcnt + CBITS'(1);
            end
          end
          TRACK, LOCKED: begin
            // Timeout has priority over a coincident tick.
            if (gcnt == TIMEOUT) begin
              late     <= 1'b1;
              state    <= FAULT;
              fault    <= 1'b1;
              locked   <= 1'b0;
              gcnt     <= '0;
              good_cnt <= '0;
            end else if (tick) begin
              period <= interval;
              gcnt   <= '0;
              if (interval < WIN_LO) begin
                early    <= 1'b1;
                state    <= FAULT;
                fault    <= 1'b1;
                locked   <= 1'b0;
                good_cnt <= '0;
              end else begin
                good_cnt <= good_inc;
                if (state == TRACK && good_inc == LOCK_C) begin
                  state  <= LOCKED;
                  locked <= 1'b1;
                end
              end
            end else begin
              gcnt <= gcnt + CBITS'(1);
            end
          end
          FAULT: begin
            gcnt <= '0;
            if (clr) begin
              state <= ACQ;
              fault <= 1'b0;
            end
          end
          default: begin
            state    <= IDLE;
            gcnt     <= '0;
            locked   <= 1'b0;
            fault    <= 1'b0;
            good_cnt <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_tick_monitor.sv
// Scoreboard bench for tick_monitor (N=10, TOL=1, LOCK=3 -> window 10..12).
module tb_tick_monitor;
  localparam int N     = 10;
  localparam int TOL   = 1;
  localparam int LOCK  = 3;
  localparam int CBITS = 8;

  localparam int S_IDLE = 0, S_ACQ = 1, S_TRACK = 2, S_LOCKED = 3, S_FAULT = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic en = 1'b0, tick = 1'b0, clr = 1'b0;
  logic locked, fault, early, late;
  logic [CBITS-1:0] period;
  logic [7:0] good_cnt;

  tick_monitor #(.N(N), .CBITS(CBITS), .TOL(TOL), .LOCK(LOCK)) dut (
    .clk(clk), .rst(rst), .en(en), .tick(tick), .clr(clr),
    .locked(locked), .fault(fault), .early(early), .late(late),
    .period(period), .good_cnt(good_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       locked;
    logic       fault;
    logic       early;
    logic       late;
    logic [7:0] period;
    logic [7:0] good;
  } exp_t;

  exp_t sb_q[$];
  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;

  // Reference model: "since" counts cycles elapsed since the last accepted tick.
  int   m_state = S_IDLE;
  int   m_since = 0;
  int   m_period = 0;
  int   m_good = 0;
  logic m_early = 1'b0, m_late = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%0d expected=%0d", tag, cyc, got, exp);
    end
  endtask

  task automatic model_reset();
    m_state = S_IDLE; m_since = 0; m_period = 0; m_good = 0;
    m_early = 1'b0; m_late = 1'b0;
  endtask

  task automatic model_step(input logic e, input logic t, input logic c);
    m_early = 1'b0;
    m_late  = 1'b0;
    if (!rst) begin
      model_reset();
    end else if (!e) begin
      m_state = S_IDLE; m_since = 0; m_good = 0;
    end else if (m_state == S_IDLE) begin
      m_state = S_ACQ;
    end else if (m_state == S_ACQ) begin
      if (t) begin m_state = S_TRACK; m_since = 0; m_good = 0; end
    end else if (m_state == S_FAULT) begin
      if (c) begin m_state = S_ACQ; m_since = 0; end
    end else begin
      m_since++;
      if (m_since > N + 1 + TOL) begin
        m_late = 1'b1; m_state = S_FAULT; m_good = 0;
      end else if (t) begin
        m_period = m_since;
        if (m_since < N + 1 - TOL) begin
          m_early = 1'b1; m_state = S_FAULT; m_good = 0;
        end else begin
          if (m_good < 255) m_good++;
          if (m_state == S_TRACK && m_good == LOCK) m_state = S_LOCKED;
        end
        m_since = 0;
      end
    end
  endtask

  function automatic exp_t model_out();
    exp_t x;
    x.locked = (m_state == S_LOCKED);
    x.fault  = (m_state == S_FAULT);
    x.early  = m_early;
    x.late   = m_late;
    x.period = 8'(m_period);
    x.good   = 8'(m_good);
    return x;
  endfunction

  task automatic compare_top();
    exp_t x;
    x = sb_q.pop_front();
    check("locked",   32'(locked),   32'(x.locked));
    check("fault",    32'(fault),    32'(x.fault));
    check("early",    32'(early),    32'(x.early));
    check("late",     32'(late),     32'(x.late));
    check("period",   32'(period),   32'(x.period));
    check("good_cnt", 32'(good_cnt), 32'(x.good));
  endtask

  task automatic step(input logic e, input logic t, input logic c);
    en = e; tick = t; clr = c;
    model_step(e, t, c);
    sb_q.push_back(model_out());
    @(posedge clk);
    #1;
    cyc++;
    $display("cyc=%0d rst=%0b en=%0b tick=%0b clr=%0b locked=%0b fault=%0b early=%0b late=%0b period=%0d good_cnt=%0d",
             cyc, rst, e, t, c, locked, fault, early, late, period, good_cnt);
    compare_top();
  endtask

  // k-1 quiet cycles then a tick: interval of k cycles from the previous tick.
  task automatic tick_after(input int k);
    for (int i = 0; i < k - 1; i++) step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d got=running expected=finished", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    logic seen;
    #1;
    model_reset();
    sb_q.push_back(model_out());
    compare_top();

    // Held in reset with random en/tick: everything stays 0.
    for (int i = 0; i < 3; i++) step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0);

    // Acquire and lock at interval 11.
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) tick_after(11);
    check("lock_locked", 32'(locked), 32'd1);
    check("lock_good", 32'(good_cnt), 32'd3);
    check("lock_period", 32'(period), 32'd11);
    tick_after(12);
    tick_after(10);
    check("lock_hold_good", 32'(good_cnt), 32'd5);

    // Early tick after 9 cycles.
    tick_after(9);
    check("early_pulse", 32'(early), 32'd1);
    check("early_fault", 32'(fault), 32'd1);
    check("early_period", 32'(period), 32'd9);
    step(1'b1, 1'b0, 1'b0);
    check("early_one_cycle", 32'(early), 32'd0);

    // clr with coincident tick: tick ignored, next tick is the first.
    step(1'b1, 1'b1, 1'b1);
    check("clr_fault", 32'(fault), 32'd0);
    tick_after(5);
    check("clr_period_kept", 32'(period), 32'd9);
    for (int i = 0; i < 3; i++) tick_after(11);
    check("relock", 32'(locked), 32'd1);

    // Withheld tick: late exactly 13 edges after the last tick.
    n = 0; seen = 1'b0;
    while (!seen && n < 20) begin
      step(1'b1, 1'b0, 1'b0);
      n++;
      seen = late;
    end
    check("late_delay", 32'(n), 32'd13);
    check("late_period", 32'(period), 32'd11);
    step(1'b1, 1'b1, 1'b0);

    // Back to TRACK with good_cnt=2; clr outside FAULT is harmless.
    step(1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b0);
    tick_after(11);
    step(1'b1, 1'b0, 1'b1);
    tick_after(10);
    check("track_good2", 32'(good_cnt), 32'd2);

    // Asynchronous reset mid-cycle.
    #3;
    rst = 1'b0;
    #1;
    model_reset();
    sb_q.push_back(model_out());
    compare_top();
    step(1'b1, 1'b1, 1'b0);
    rst = 1'b1;
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    tick_after(11);
    check("post_rst_good", 32'(good_cnt), 32'd1);

    // en=0 clears counts, keeps period.
    step(1'b0, 1'b1, 1'b0);
    check("dis_period", 32'(period), 32'd11);
    step(1'b0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/tick_monitor.md
TICK_MONITOR -- requirements
Module: tick_monitor

Interface
REQ-001 Parameter N, default 200000: nominal period term; expected tick interval is N+1 cycles.
REQ-002 Parameter CBITS, default 18: width of interval counter and period output; SHALL hold N+TOL+2.
REQ-003 Parameter TOL, default 2: allowed deviation of interval, in cycles, either direction.
REQ-004 Parameter LOCK, default 4: consecutive in-window intervals required to lock; 1..255.
REQ-005 clk  input  1  single clock, rising edge.
REQ-006 rst  input  1  reset, asynchronous, active-low.
REQ-007 en  input  1  monitor enable.
REQ-008 tick  input  1  single-cycle pulse from the upstream period generator.
REQ-009 clr  input  1  clears fault.
REQ-010 locked  output  1  high while in LOCKED.
REQ-011 fault  output  1  high while in FAULT.
REQ-012 early  output  1  one-cycle pulse: interval below window.
REQ-013 late  output  1  one-cycle pulse: interval above window, or timeout.
REQ-014 period  output  CBITS  last measured interval, in cycles.
REQ-015 good_cnt  output  8  consecutive in-window intervals, saturating at 255.

Function
REQ-016 All outputs SHALL be registered; each response SHALL be visible the cycle after the clk edge sampling its cause.
REQ-017 gcnt (CBITS) SHALL increment every cycle in ACQ/TRACK/LOCKED, reset to 0 on each accepted tick, and hold 0 in IDLE/FAULT.
REQ-018 Interval of an accepted tick SHALL be gcnt+1; window is N+1-TOL .. N+1+TOL inclusive.
REQ-019 States SHALL be IDLE, ACQ, TRACK, LOCKED, FAULT.
REQ-020 en=0 in any state -> IDLE, clearing gcnt and good_cnt; fault clears; period holds.
REQ-021 IDLE with en=1 -> ACQ.
REQ-022 ACQ: tick -> TRACK, gcnt=0, good_cnt=0; period not updated; no timeout in ACQ.
REQ-023 TRACK/LOCKED in-window tick -> period=interval, good_cnt+1 (saturating); TRACK -> LOCKED when updated good_cnt equals LOCK.
REQ-024 TRACK/LOCKED tick with interval < N+1-TOL -> period=interval, early pulse, -> FAULT.
REQ-025 TRACK/LOCKED with gcnt == N+TOL+1 -> late pulse, -> FAULT, whether or not tick is present that cycle; period not updated.
REQ-026 Entering FAULT SHALL clear good_cnt; FAULT holds until clr=1, then -> ACQ (en=1) or IDLE (en=0).
REQ-027 clr with tick in the same cycle: clr wins and tick is ignored; the next tick is treated as first.
REQ-028 clr outside FAULT SHALL have no effect.
REQ-029 gcnt SHALL never wrap; REQ-025 bounds it below 2^CBITS.

Reset
REQ-030 rst=0 SHALL force IDLE, gcnt=0, and all outputs to 0 (period=0, good_cnt=0) immediately, independent of clk.
REQ-031 On rst release, first state change SHALL occur at the first clk edge with rst=1.
REQ-032 rst assertion mid-operation (any state) SHALL discard all measurement history.

Verification (N=10, TOL=1, LOCK=3; window 10..12)
REQ-033 rst=0 for 3 cycles with random en/tick -> all outputs 0 throughout; release, en=0 -> state stays IDLE.
REQ-034 en=1, tick every 11 cycles -> 1st tick enters TRACK; after 4th tick locked=1, good_cnt=3, period=11; no early/late.
REQ-035 Locked, next tick after 9 cycles -> early=1 one cycle, fault=1, locked=0, period=9, good_cnt=0.
REQ-036 Locked, tick withheld -> late=1 one cycle when gcnt reaches 12; fault=1; period stays 11.
REQ-037 In FAULT, clr=1 with tick in the same cycle -> fault=0 next cycle, state ACQ; following tick -> TRACK with period unchanged.
REQ-038 In TRACK with good_cnt=2, rst pulsed low mid-cycle -> outputs 0 before next clk edge; en=1 after release -> ACQ.
